// File: rtl/serial_arith_pkg.sv
// Shared types and limits for the bit-serial arithmetic blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_arith_pkg;

    // Sequencer states for the serial subtractor; encoding 2'b11 is unused.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int SUB_MAX_WIDTH = 32;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, bout = borrow out.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of its inputs).
// Ports: a, b, bin (inputs); diff, bout (outputs).
module full_subtractor (
    output logic diff,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);

    assign diff = a ^ b ^ bin;
    // Borrow when b beats a outright, or when they tie and a borrow is pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial d = a - b - bin, LSB first, through a single full_subtractor cell.
// Latency: WIDTH cycles from the accepting edge to done; one op per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; requests in RUN/DONE are dropped.
// Ports: clk, rst_n, start, a, b, bin (inputs); d, bout, ovf, busy, done (registered outputs).
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > SUB_MAX_WIDTH) begin : g_width_check
        $error("serial_subtractor: WIDTH out of range");
    end

    sub_state_t       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 low difference bits; the MSB comes straight from the
    // cell on the final edge, so it never needs a flop of its own here.
    logic [WIDTH-2:0] res;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;

    logic             diff_bit;
    logic             br_nxt;

    full_subtractor u_cell (
        .diff (diff_bit),
        .bout (br_nxt),
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br)
    );

    // Status flags decode straight from the state flop, so they stay registered.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    // New bit enters at the top; after WIDTH-1 shifts bit 0 holds diff_0.
                    res  <= (WIDTH-1)'({diff_bit, res} >> 1);
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        d     <= {diff_bit, res};
                        bout  <= br_nxt;
                        ovf   <= (a_msb ^ b_msb) & (diff_bit ^ a_msb);
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    // IDLE, and the unused encoding recovers through here.
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=4 and WIDTH=8 against an arithmetic timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_subtractor;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  start_i = '0;
    logic [31:0] a_i [2];
    logic [31:0] b_i [2];
    logic [1:0]  bin_i = '0;

    logic [3:0]  d4;
    logic [7:0]  d8;
    logic [1:0]  bout_o, ovf_o, busy_o, done_o;
    logic [31:0] d_o [2];
    assign d_o[0] = 32'(d4);
    assign d_o[1] = 32'(d8);

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_i[0]),
        .a     (a_i[0][3:0]),
        .b     (b_i[0][3:0]),
        .bin   (bin_i[0]),
        .d     (d4),
        .bout  (bout_o[0]),
        .ovf   (ovf_o[0]),
        .busy  (busy_o[0]),
        .done  (done_o[0])
    );

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_i[1]),
        .a     (a_i[1][7:0]),
        .b     (b_i[1][7:0]),
        .bin   (bin_i[1]),
        .d     (d8),
        .bout  (bout_o[1]),
        .ovf   (ovf_o[1]),
        .busy  (busy_o[1]),
        .done  (done_o[1])
    );

    int n_chk = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int wid(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    // Reference arithmetic: plain integer subtraction, range checks on signed values.
    function automatic void ref_sub(input int w, input logic [31:0] av, input logic [31:0] bv,
                                    input logic bi, output logic [31:0] dv,
                                    output logic bo, output logic ov);
        longint m, half, ua, ub, sa, sb, r, sr;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(av) & m;
        ub   = longint'(bv) & m;
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sb   = (ub >= half) ? ub - (m + 1) : ub;
        r    = ua - ub - longint'(bi);
        sr   = sa - sb - longint'(bi);
        dv   = 32'(r & m);
        bo   = (ua < ub + longint'(bi));
        ov   = (sr >= half) || (sr < -half);
    endfunction

    // Timeline model: an accepted op at edge n shows busy after edges n..n+W-1,
    // results and done after edge n+W, and the next accept is possible at n+W+2.
    int          cyc = 0;
    int          acc [2] = '{0, 0};
    int          free_at [2] = '{0, 0};
    bit          act [2] = '{0, 0};
    logic [31:0] pend_d [2] = '{0, 0};
    logic        pend_bo [2] = '{0, 0};
    logic        pend_ov [2] = '{0, 0};
    logic [31:0] exp_d [2] = '{0, 0};
    logic        exp_bo [2] = '{0, 0};
    logic        exp_ov [2] = '{0, 0};
    logic        exp_busy [2] = '{0, 0};
    logic        exp_done [2] = '{0, 0};

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                act[k] = 0; free_at[k] = 0;
                exp_d[k] = '0; exp_bo[k] = 0; exp_ov[k] = 0;
                exp_busy[k] = 0; exp_done[k] = 0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (act[k] && cyc == acc[k] + wid(k)) begin
                    exp_d[k]  = pend_d[k];
                    exp_bo[k] = pend_bo[k];
                    exp_ov[k] = pend_ov[k];
                end
                if (start_i[k] && cyc >= free_at[k]) begin
                    acc[k]     = cyc;
                    free_at[k] = cyc + wid(k) + 2;
                    act[k]     = 1;
                    ref_sub(wid(k), a_i[k], b_i[k], bin_i[k], pend_d[k], pend_bo[k], pend_ov[k]);
                end
                exp_busy[k] = act[k] && cyc >= acc[k] && cyc < acc[k] + wid(k);
                exp_done[k] = act[k] && cyc == acc[k] + wid(k);
            end
        end
    end

    // Cycle-by-cycle compare of every output against the model.
    initial forever begin
        @(negedge clk);
        if (rst_n && check_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("busy w%0d cyc%0d", wid(k), cyc), 32'(busy_o[k]), 32'(exp_busy[k]));
                chk($sformatf("done w%0d cyc%0d", wid(k), cyc), 32'(done_o[k]), 32'(exp_done[k]));
                chk($sformatf("d w%0d cyc%0d", wid(k), cyc), d_o[k], exp_d[k]);
                chk($sformatf("bout w%0d cyc%0d", wid(k), cyc), 32'(bout_o[k]), 32'(exp_bo[k]));
                chk($sformatf("ovf w%0d cyc%0d", wid(k), cyc), 32'(ovf_o[k]), 32'(exp_ov[k]));
            end
        end
    end

    task automatic wait_done(input int k, output int n, output bit ok);
        ok = 0;
        n  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (done_o[k]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout w%0d: got no done, expected done within 50 cycles", wid(k));
        end
    endtask

    // Directed op with hand-computed expectations, including latency and pulse width.
    task automatic run_op(input int k, input logic [31:0] av, input logic [31:0] bv, input logic bi,
                          input logic [31:0] ed, input logic eb, input logic eo);
        int  n;
        bit  ok;
        @(negedge clk);
        a_i[k] = av; b_i[k] = bv; bin_i[k] = bi; start_i[k] = 1'b1;
        @(negedge clk);
        start_i[k] = 1'b0;
        a_i[k] = $urandom; b_i[k] = $urandom; bin_i[k] = 1'($urandom_range(0, 1));
        wait_done(k, n, ok);
        if (ok) begin
            chk($sformatf("lat w%0d %0h-%0h", wid(k), av, bv), 32'(n), 32'(wid(k)));
            chk($sformatf("lit_d w%0d %0h-%0h", wid(k), av, bv), d_o[k], ed);
            chk($sformatf("lit_bout w%0d %0h-%0h", wid(k), av, bv), 32'(bout_o[k]), 32'(eb));
            chk($sformatf("lit_ovf w%0d %0h-%0h", wid(k), av, bv), 32'(ovf_o[k]), 32'(eo));
        end
        @(negedge clk);
        chk($sformatf("lit_done_1cyc w%0d", wid(k)), 32'(done_o[k]), 32'd0);
        chk($sformatf("lit_busy_after w%0d", wid(k)), 32'(busy_o[k]), 32'd0);
    endtask

    initial begin
        int  ndone, first_i, second_i, n;
        bit  ok;
        a_i[0] = '0; a_i[1] = '0; b_i[0] = '0; b_i[1] = '0;

        repeat (3) @(negedge clk);
        chk("rst_d4", d_o[0], 32'd0);
        chk("rst_d8", d_o[1], 32'd0);
        chk("rst_bout", 32'(bout_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        rst_n = 1'b1;
        check_en = 1'b1;

        run_op(0, 32'h7, 32'h3, 1'b0, 32'h4, 1'b0, 1'b0);
        run_op(0, 32'h3, 32'h7, 1'b0, 32'hC, 1'b1, 1'b0);
        run_op(0, 32'h8, 32'h1, 1'b0, 32'h7, 1'b0, 1'b1);
        run_op(0, 32'h5, 32'hB, 1'b0, 32'hA, 1'b1, 1'b1);
        run_op(0, 32'hF, 32'hF, 1'b0, 32'h0, 1'b0, 1'b0);

        // start held high, operands churned every cycle.
        @(negedge clk);
        a_i[0] = 32'h7; b_i[0] = 32'h3; bin_i[0] = 1'b0; start_i[0] = 1'b1;
        ndone = 0; first_i = 0; second_i = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done_o[0]) begin
                ndone++;
                if (ndone == 1) begin
                    first_i = i;
                    chk("hold_first_d", d_o[0], 32'h4);
                    chk("hold_first_bout", 32'(bout_o[0]), 32'd0);
                    chk("hold_first_ovf", 32'(ovf_o[0]), 32'd0);
                end else if (ndone == 2) begin
                    second_i = i;
                end
            end
            a_i[0] = $urandom; b_i[0] = $urandom; bin_i[0] = 1'($urandom_range(0, 1));
        end
        start_i[0] = 1'b0;
        chk("hold_done_count", 32'(ndone), 32'd3);
        chk("hold_first_lat", 32'(first_i), 32'd5);
        chk("hold_period", 32'(second_i - first_i), 32'd6);
        wait_done(0, n, ok);
        @(negedge clk);

        run_op(0, 32'h0, 32'h0, 1'b1, 32'hF, 1'b1, 1'b0);

        // Reset while cnt=2: everything clears at once, no done afterwards.
        @(negedge clk);
        a_i[0] = 32'h5; b_i[0] = 32'h3; bin_i[0] = 1'b0; start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_d", d_o[0], 32'd0);
        chk("midrst_bout", 32'(bout_o[0]), 32'd0);
        chk("midrst_ovf", 32'(ovf_o[0]), 32'd0);
        chk("midrst_busy", 32'(busy_o[0]), 32'd0);
        chk("midrst_done", 32'(done_o[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        run_op(0, 32'h9, 32'h2, 1'b0, 32'h7, 1'b0, 1'b1);
        run_op(1, 32'h80, 32'h01, 1'b0, 32'h7F, 1'b0, 1'b1);
        run_op(1, 32'h00, 32'hFF, 1'b1, 32'h00, 1'b1, 1'b0);

        // Random traffic on both widths; model checks every cycle.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                start_i[k] = ($urandom_range(0, 3) == 0);
                a_i[k]     = $urandom;
                b_i[k]     = $urandom;
                bin_i[k]   = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        start_i = '0;
        repeat (14) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
